mole_scheduler: RTL

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: requests a random mole pattern, lights it for a
// bounded window, scores hits and misses from button rising edges, and runs a fixed number of rounds.
module mole_scheduler #(
    parameter int NUM_LEDS    = 18,
    parameter int UP_CYCLES   = 50000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int GAME_ROUNDS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] rnd_value,
    input  logic [17:0] btn,
    output logic        rnd_req,
    output logic [17:0] led,
    output logic [7:0]  score,
    output logic [7:0]  misses,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_UP   = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(((TMAX > 4) ? TMAX : 4) + 1);
    localparam logic [TW-1:0] UP_LAST  = TW'(UP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] REQ_LAST = TW'(2);
    localparam logic [17:0]   LED_MASK = (NUM_LEDS >= 18) ? 18'h3FFFF : 18'((1 << NUM_LEDS) - 1);

    // Generator link: rnd_req is held high for the three REQ cycles; the
    // generator answers with rnd_value two cycles later, so only the third cycle is sampled.

    state_t          state, state_n;
    logic [17:0]     mask, mask_n, mask_left, mask_cap;
    logic [TW-1:0]   timer, timer_n;
    logic [7:0]      rounds_left, rounds_n;
    logic [17:0]     btn_prev, rise;
    logic [7:0]      score_n, misses_n;
    logic            hit, wrong, timeout_miss;

    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign rise      = btn & ~btn_prev & LED_MASK;
    assign hit       = |(rise & mask);
    assign wrong     = |(rise & ~mask);
    assign mask_left = mask & ~rise;
    assign mask_cap  = ((rnd_value & LED_MASK) == 18'h0) ? 18'h00001 : (rnd_value & LED_MASK);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mask        <= '0;
            timer       <= '0;
            rounds_left <= '0;
            btn_prev    <= '0;
            score       <= '0;
            misses      <= '0;
            led         <= '0;
            rnd_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            mask        <= mask_n;
            timer       <= timer_n;
            rounds_left <= rounds_n;
            btn_prev    <= btn;
            score       <= score_n;
            misses      <= misses_n;
            // LEDs follow the registered state, so they trail a state change by one cycle.
            led         <= (state == S_UP) ? mask : 18'h0;
            rnd_req     <= (state_n == S_REQ);
            busy        <= (state_n == S_REQ) || (state_n == S_UP) || (state_n == S_GAP);
            done        <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n      = state;
        mask_n       = mask;
        timer_n      = timer;
        rounds_n     = rounds_left;
        score_n      = score;
        misses_n     = misses;
        timeout_miss = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n  = S_REQ;
                    score_n  = '0;
                    misses_n = '0;
                    rounds_n = 8'(GAME_ROUNDS);
                    timer_n  = '0;
                    mask_n   = '0;
                end
            end
            S_REQ: begin
                if (timer == REQ_LAST) begin
                    mask_n  = mask_cap;
                    state_n = S_UP;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_UP: begin
                // Hits are removed first so a last-cycle hit on the last mole is not also a timeout.
                mask_n  = mask_left;
                timer_n = timer + 1'b1;
                if (mask_left == 18'h0) begin
                    state_n = S_GAP;
                    timer_n = '0;
                end else if (timer == UP_LAST) begin
                    state_n      = S_GAP;
                    timer_n      = '0;
                    timeout_miss = 1'b1;
                end
                score_n  = sat_add(score, {1'b0, hit});
                misses_n = sat_add(misses, {1'b0, wrong} + {1'b0, timeout_miss});
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_n  = '0;
                    rounds_n = rounds_left - 1'b1;
                    state_n  = (rounds_left == 8'd1) ? S_DONE : S_REQ;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
